// File: rtl/hamming_seq.sv
// hamming_seq: job sequencer that reads 11-bit messages, SECDED-encodes them
// and writes 16-bit codewords back over a granted data-memory port.
module hamming_seq #(
    parameter int MSG_COUNT = 15,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30,
    parameter int AW        = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    output logic          Busy,
    output logic          Done,
    output logic          MemReq,
    input  logic          MemGnt,
    output logic [AW-1:0] MemAddr,
    output logic          MemWrEn,
    output logic [7:0]    MemWrData,
    input  logic [7:0]    MemRdData
);
    typedef enum logic [2:0] {IDLE, REQ, RD_LO, RD_HI, WR_HI, WR_LO, DONE} state_t;
    state_t state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [7:0] lo_q, lo_d;
    logic [2:0] hi_q, hi_d;
    logic [11:1] d;
    logic p8, p4, p2, p1, p0;
    logic [AW-1:0] src, dst;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        d   = {hi_q, lo_q};
        p8  = ^d[11:5];
        p4  = ^d[11:8] ^ ^d[4:2];
        p2  = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1  = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0  = ^d ^ p8 ^ p4 ^ p2 ^ p1;
        src = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
        dst = AW'(DST_BASE) + AW'({idx_q, 1'b0});
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        Busy      = !(state_q inside {IDLE, DONE});
        Done      = state_q == DONE;
        MemReq    = Busy;
        MemAddr   = '0;
        MemWrData = '0;
        MemWrEn   = 1'b0;
        case (state_q)
            IDLE, DONE: if (Start) begin
                state_d = REQ;
                idx_d   = '0;
            end
            REQ: if (MemGnt) state_d = RD_LO;
            RD_LO: begin
                MemAddr = src;
                if (MemGnt) begin
                    lo_d    = MemRdData;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                MemAddr = src + AW'(1);
                if (MemGnt) begin
                    hi_d    = MemRdData[2:0];
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                MemAddr   = dst + AW'(1);
                MemWrData = {d[11:5], p8};
                MemWrEn   = MemGnt;
                if (MemGnt) state_d = WR_LO;
            end
            WR_LO: begin
                MemAddr   = dst;
                MemWrData = {d[4:2], p4, d[1], p2, p1, p0};
                MemWrEn   = MemGnt;
                if (MemGnt) begin
                    idx_d   = idx_q + 7'd1;
                    state_d = (idx_q == 7'(MSG_COUNT - 1)) ? DONE : RD_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hamming_seq.sv
// tb_hamming_seq: directed checks of the encode sequencer against a shared
// byte memory, with one single-message and one full-job instance.
module tb_hamming_seq;
    logic Clk = 0, Reset_n = 0, start1 = 0, start15 = 0, gnt = 1;
    logic busy1, done1, req1, we1, busy15, done15, req15, we15;
    logic [7:0] a1, a15, wd1, wd15, rd, addr, wd;
    logic we;
    logic [7:0] mem [256];
    logic [7:0] src_copy [30];
    logic [10:0] msg [15];
    bit stall [512];
    bit startp [512];
    int checks = 0, errors = 0, writes = 0, badwr = 0, cyc, w0, n;

    logic [7:0] t_slo [4] = '{8'hFF, 8'h00, 8'h01, 8'h00};
    logic [7:0] t_shi [4] = '{8'h07, 8'h00, 8'h00, 8'hFC};
    logic [7:0] t_elo [4] = '{8'hFF, 8'h00, 8'h0F, 8'h17};
    logic [7:0] t_ehi [4] = '{8'hFF, 8'h00, 8'h00, 8'h81};

    assign addr = a1 | a15;
    assign we   = we1 | we15;
    assign wd   = wd1 | wd15;
    assign rd   = mem[addr];

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (we) begin
        mem[addr] <= wd;
        writes    <= writes + 1;
        if (!gnt) badwr <= badwr + 1;
    end

    hamming_seq #(.MSG_COUNT(1)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start1), .Busy(busy1), .Done(done1),
        .MemReq(req1), .MemGnt(gnt), .MemAddr(a1), .MemWrEn(we1),
        .MemWrData(wd1), .MemRdData(rd)
    );

    hamming_seq u15 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start15), .Busy(busy15), .Done(done15),
        .MemReq(req15), .MemGnt(gnt), .MemAddr(a15), .MemWrEn(we15),
        .MemWrData(wd15), .MemRdData(rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference built from codeword positions: parity k covers positions with bit k set.
    function automatic logic [15:0] enc(input logic [10:0] dv);
        logic [15:0] w;
        int k;
        w = '0;
        k = 0;
        for (int j = 1; j < 16; j++) if ((j & (j - 1)) != 0) begin
            w[j] = dv[k];
            k++;
        end
        for (int p = 1; p < 16; p = p * 2)
            for (int j = 1; j < 16; j++) if ((j & p) != 0 && j != p) w[p] = w[p] ^ w[j];
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic run(input bit big, output int c);
        int k;
        k = 0;
        if (big) start15 = 1; else start1 = 1;
        @(posedge Clk); #1;
        start1  = 0;
        gnt     = !stall[1];
        start15 = big & startp[1];
        while (!(big ? done15 : done1) && k < 300) begin
            @(posedge Clk); #1;
            k++;
            gnt     = !stall[k + 1];
            start15 = big & startp[k + 1];
        end
        gnt = 1;
        start15 = 0;
        c = k + 1;
    endtask

    task automatic clear_dst();
        for (int i = 30; i < 60; i++) mem[i] = 8'h00;
    endtask

    task automatic verify(input int from, input int to, input string tag);
        logic [15:0] w;
        for (int i = from; i < to; i++) begin
            w = enc(msg[i]);
            check({tag, "_lo"}, mem[30 + 2 * i], w[7:0]);
            check({tag, "_hi"}, mem[31 + 2 * i], w[15:8]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #12;
        check("rst15", {busy15, done15, req15, we15, a15, wd15}, 0);
        check("rst1", {busy1, done1, req1, we1, a1, wd1}, 0);
        Reset_n = 1;
        @(posedge Clk); #1;
        check("idle15", {busy15, done15, req15, we15, a15, wd15}, 0);

        for (int t = 0; t < 4; t++) begin
            mem[0] = t_slo[t];
            mem[1] = t_shi[t];
            mem[30] = 8'h5A;
            mem[31] = 8'h5A;
            w0 = writes;
            run(0, cyc);
            check("one_cyc", cyc, 6);
            check("one_wr", writes - w0, 2);
            check("one_lo", mem[30], t_elo[t]);
            check("one_hi", mem[31], t_ehi[t]);
        end

        for (int i = 0; i < 15; i++) begin
            msg[i] = 11'($urandom);
            mem[2 * i] = msg[i][7:0];
            mem[2 * i + 1] = {5'($urandom | 1), msg[i][10:8]};
        end
        for (int i = 0; i < 30; i++) src_copy[i] = mem[i];
        clear_dst();
        run(1, cyc);
        check("job_cyc", cyc, 62);
        verify(0, 15, "job");
        for (int i = 0; i < 30; i++) check("src", mem[i], src_copy[i]);
        repeat (3) @(posedge Clk);
        #1 check("done_hold", done15, 1);

        clear_dst();
        stall[1] = 1; stall[2] = 1; stall[3] = 1; stall[23] = 1; stall[24] = 1;
        run(1, cyc);
        check("stall_cyc", cyc, 67);
        check("stall_wr", badwr, 0);
        verify(0, 15, "stall");
        for (int i = 0; i < 512; i++) stall[i] = 0;

        clear_dst();
        w0 = writes;
        start15 = 1;
        @(posedge Clk); #1;
        start15 = 0;
        repeat (31) @(posedge Clk);
        #1 check("m7_addr", {busy15, a15}, {1'b1, 8'd45});
        Reset_n = 0;
        #1 check("abort_out", {busy15, done15, req15, we15, a15, wd15}, 0);
        check("abort_wr", writes - w0, 14);
        repeat (3) @(posedge Clk);
        #1 check("abort_hold", writes - w0, 14);
        verify(0, 7, "abort");
        check("m7_lo", mem[44], 0);
        check("m7_hi", mem[45], 0);
        Reset_n = 1;
        run(1, cyc);
        check("rerun_cyc", cyc, 62);
        verify(0, 15, "rerun");

        clear_dst();
        startp[10] = 1;
        run(1, cyc);
        check("ign_cyc", cyc, 62);
        startp[10] = 0;
        verify(0, 15, "ign");
        clear_dst();
        start15 = 1;
        @(posedge Clk); #1;
        check("restart", {done15, req15}, 2'b01);
        start15 = 0;
        @(posedge Clk); #1;
        check("i0_lo", {busy15, a15}, {1'b1, 8'd0});
        @(posedge Clk); #1;
        check("i0_hi", {busy15, a15}, {1'b1, 8'd1});
        n = 3;
        while (!done15 && n < 300) begin
            @(posedge Clk); #1;
            n++;
        end
        check("job2_cyc", n, 62);
        verify(0, 15, "job2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_seq.md
# hamming_seq

Hardware sequencer for the program-1 SECDED Hamming encode job. It owns the data-memory port for the duration of a job, acquiring it through a request/grant handshake with the core. It reads MSG_COUNT 11-bit messages from the source region, inserts parity bits p8/p4/p2/p1 and overall parity p0, and writes the encoded 16-bit words to the destination region. It sits beside the core on the data-memory bus and raises Done on completion, so a job can be offloaded from software.

## Interface
- MSG_COUNT, 15, messages per job (1..127)
- SRC_BASE, 0, byte address of message 0 low byte
- DST_BASE, 30, byte address of encoded word 0 low byte
- AW, 8, memory address width
- Clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  job request, sampled only in IDLE
- Busy  out  1  high in every state except IDLE and DONE
- Done  out  1  job complete; held high until next accepted Start or reset
- MemReq  out  1  request for data-memory port
- MemGnt  in  1  grant from bus owner
- MemAddr  out  AW  byte address
- MemWrEn  out  1  write strobe
- MemWrData  out  8  write data
- MemRdData  in  8  read data, combinational (valid same cycle as MemAddr)

## Operation
- Memory layout, message i: src lo byte at SRC_BASE+2i = d[8:1]; src hi byte at SRC_BASE+2i+1, bits [2:0] = d[11:9], bits [7:3] ignored.
- Encoding, all XOR: p8 = ^d[11:5]; p4 = ^d[11:8] ^ ^d[4:2]; p2 = d11^d10^d7^d6^d4^d3^d1; p1 = d11^d9^d7^d5^d4^d2^d1; p0 = ^d[11:1]^p8^p4^p2^p1.
- Output: DST_BASE+2i+1 = {d[11:5],p8}; DST_BASE+2i = {d[4:2],p4,d[1],p2,p1,p0}.
- States: IDLE, REQ, RD_LO, RD_HI, WR_HI, WR_LO, DONE.
- IDLE: on Start go to REQ and clear Done. DONE: on Start go to REQ and clear Done, otherwise hold.
- REQ: MemReq=1. Advance to RD_LO when MemGnt=1.
- RD_LO captures MemRdData into lo register; RD_HI captures bits [2:0]; WR_HI writes hi byte; WR_LO writes lo byte, then increments message index i.
- After WR_LO: if i == MSG_COUNT-1, go to DONE with MemReq dropped; otherwise go to RD_LO.
- MemReq is held from REQ through the last WR_LO.
- Stall: in any RD/WR state with MemGnt=0, state, index and capture registers hold. MemWrEn = (WR_HI|WR_LO) & MemGnt.
- Outside RD/WR states: MemAddr=0, MemWrData=0, MemWrEn=0.
- Start while Busy is ignored.
- Address arithmetic is mod 2^AW; wrap is not flagged.
- Parity is computed combinationally from the captured registers.

## Timing
- Reset values: state IDLE, i=0, Busy=0, Done=0, MemReq=0, MemAddr=0, MemWrEn=0, MemWrData=0.
- Reset asserted mid-job aborts immediately. Writes already performed stay in memory; no further writes occur.
- All outputs are Moore, registered state decode. The exception is MemWrEn, which is additionally gated by MemGnt.
- Start sampled at edge 0 → REQ in cycle 1.
- With MemGnt constantly high: 4 cycles per message; Done rises in cycle 2+4*MSG_COUNT (62 for the default). Each stalled cycle adds exactly one cycle.
- Start and MemGnt deassertion in the same cycle: follow the state rules above independently.

## Test plan
- Single message d=11'h7FF (src bytes 0xFF, 0x07), MSG_COUNT=1, grant tied high → dst bytes 0xFF/0xFF, Done in cycle 6, MemWrEn high for exactly 2 cycles.
- d=11'h000 → 0x00/0x00. d=11'h001 (src lo 0x01, hi 0x00) → dst hi 0x00, lo 0x0F.
- 15 random messages with garbage in src hi bits [7:3], default params → all 30 dst bytes match the reference model, Done at cycle 62, src region unmodified.
- MemGnt low in REQ for 3 cycles and for 2 cycles during WR_HI of message 4 → no write while MemGnt=0, results still correct, Done delayed by 5 cycles.
- Reset_n pulsed low during message 7 → outputs zero asynchronously, messages 0-6 written, nothing further written. A new Start completes the full job correctly.
- Start pulsed while Busy and held high in DONE → mid-job Start ignored; second job starts from DONE, Done drops in the cycle after Start, i restarts at 0.
